// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter fed by byte writes from an rbus slave port.
//   Writes are queued in a DEPTH-entry FIFO and shifted out LSB first on txd_o.
//   Back-to-back queued bytes are sent with no idle gap between frames.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-low reset
//   en_i        rbus slave select
//   we_i        rbus write flag
//   wdata_i     byte to queue for transmission
//   status_o    {count[4:0], busy, empty, full}
//   overflow_o  sticky: a write was dropped because the FIFO was full
//   busy_o      a frame (start/data/stop) is on the line
//   txd_o       serial output, idles high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       we_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] status_o,
    output logic       overflow_o,
    output logic       busy_o,
    output logic       txd_o
);

    localparam int              DIV      = CLK_FREQ / BAUD;
    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DIV - 1);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          wrReq;
    logic          push;
    logic          pop;

    // Transmit engine
    txState_t      state;
    txState_t      stateNext;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shReg;
    logic          slotEnd;
    logic          txdNext;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wrReq   = en_i & we_i;
    assign push    = wrReq & ~full;
    assign slotEnd = (baudCnt == LAST_CNT);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        txdNext   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                txdNext = 1'b0;
                if (slotEnd) stateNext = DATA;
            end
            DATA: begin
                txdNext = shReg[bitIdx];
                if (slotEnd && bitIdx == 3'd7) stateNext = STOP;
            end
            STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (slotEnd) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; stale contents are never read
    // because the pointers and count are reset, and leaving it unreset lets it
    // map onto plain memory.
    always_ff @(posedge clk_i) begin
        if (push) mem[wrPtr] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            state      <= IDLE;
            baudCnt    <= '0;
            bitIdx     <= '0;
            shReg      <= '0;
            txd_o      <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (wrReq && full) overflow_o <= 1'b1;

            if (pop) begin
                shReg <= mem[rdPtr];
                rdPtr <= rdPtr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            state <= stateNext;

            // Slot counter restarts on every state entry and at each slot end.
            if (state == IDLE || stateNext != state || slotEnd) begin
                baudCnt <= '0;
            end else begin
                baudCnt <= baudCnt + CW'(1);
            end

            // Wraps 7 -> 0 on leaving DATA, so it is always 0 on DATA entry.
            if (state == DATA && slotEnd) bitIdx <= bitIdx + 3'd1;

            // Line outputs are registered from the current state, so they
            // follow the state by one cycle and never glitch.
            txd_o  <= txdNext;
            busy_o <= (state != IDLE);
        end
    end

    assign status_o = {5'(count), busy_o, empty, full};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo with DIV = 10 (CLK_FREQ=1000, BAUD=100).
//   Stimulus pushes every accepted byte into expQ; an independent monitor
//   decodes frames from txd_o and compares them against expQ in order.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       en_i = 1'b0;
    logic       we_i = 1'b0;
    logic [7:0] wdata_i = 8'h00;
    logic [7:0] status_o;
    logic       overflow_o;
    logic       busy_o;
    logic       txd_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .DEPTH   (16),
        .AW      (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .we_i      (we_i),
        .wdata_i   (wdata_i),
        .status_o  (status_o),
        .overflow_o(overflow_o),
        .busy_o    (busy_o),
        .txd_o     (txd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single write strobe; sampled by the DUT at the next rising edge.
    task automatic pushByte(input logic [7:0] b, input bit accept);
        en_i    = 1'b1;
        we_i    = 1'b1;
        wdata_i = b;
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        we_i = 1'b0;
        if (accept) expQ.push_back(b);
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Frame monitor: first low sample is start-slot cycle 0; each slot is
    // sampled in its middle (cycle 4 of 10). Frames cut by reset are dropped.
    initial begin : monitor
        logic [9:0] bits;
        bit         aborted;
        logic [7:0] exp;
        forever begin
            @(negedge clk_i);
            if (rst_i && !txd_o) begin
                aborted = 1'b0;
                bits    = '0;
                for (int i = 0; i < 10 * DIV; i++) begin
                    if (i > 0) @(negedge clk_i);
                    if (!rst_i) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % DIV == 4) bits[i / DIV] = txd_o;
                end
                if (!aborted) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_frame", {22'd0, bits}, 32'hFFFF_FFFF);
                    end else begin
                        exp = expQ.pop_front();
                        check("frame", {22'd0, bits}, {22'd0, 1'b1, exp, 1'b0});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int lowCnt;

        // 1. Reset state
        waitEdges(2);
        check("rst_txd", txd_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_status", status_o, 8'h02);
        check("rst_ovf", overflow_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        waitEdges(3);
        check("idle_status", status_o, 8'h02);

        // 2. Single byte, exact timing relative to the write edge t
        @(posedge clk_i);
        #1;
        pushByte(8'h55, 1'b1);                 // edge t
        check("t0_status", status_o, 8'h08);   // count=1, idle
        waitEdges(1);                          // t+1: popped
        check("t1_txd", txd_o, 1'b1);
        check("t1_status", status_o, 8'h02);
        waitEdges(1);                          // t+2: start bit
        check("t2_txd", txd_o, 1'b0);
        check("t2_busy", busy_o, 1'b1);
        waitEdges(9);                          // t+11: last start cycle
        check("t11_txd", txd_o, 1'b0);
        waitEdges(1);                          // t+12: bit0 of 0x55
        check("t12_txd", txd_o, 1'b1);
        waitEdges(89);                         // t+101: last stop cycle
        check("t101_txd", txd_o, 1'b1);
        check("t101_busy", busy_o, 1'b1);
        waitEdges(1);                          // t+102
        check("t102_busy", busy_o, 1'b0);
        check("t102_status", status_o, 8'h02);
        waitEdges(5);

        // 3. Three back-to-back frames
        pushByte(8'hA5, 1'b1);
        pushByte(8'h3C, 1'b1);
        pushByte(8'hFF, 1'b1);
        n = 0;
        while (!busy_o && n < 20) begin
            waitEdges(1);
            n++;
        end
        n = 0;
        while (busy_o && n < 400) begin
            waitEdges(1);
            n++;
        end
        check("burst3_busy_cycles", n, 300);
        waitEdges(5);
        check("burst3_drained", expQ.size(), 0);

        // 4. Fill to full, overflow on the 18th byte
        for (int i = 0; i < 18; i++) begin
            pushByte(8'(8'h10 + i), i < 17);
            if (i == 16) begin
                check("full_status", status_o, 8'h85);
                check("full_ovf", overflow_o, 1'b0);
            end
            if (i == 17) begin
                check("ovf_status", status_o, 8'h85);
                check("ovf_set", overflow_o, 1'b1);
            end
        end
        n = 0;
        while (busy_o && n < 2000) begin
            waitEdges(1);
            n++;
        end
        check("full_drain_cycles", n < 2000, 1'b1);
        check("full_drain_status", status_o, 8'h02);
        check("ovf_sticky", overflow_o, 1'b1);
        check("full_drained", expQ.size(), 0);
        waitEdges(5);

        // 5. Reset during data bit 3 with five bytes queued
        pushByte(8'hF7, 1'b1);                 // edge t, bit3 = 0
        for (int i = 0; i < 5; i++) pushByte(8'(8'h60 + i), 1'b1);
        waitEdges(40);                         // t+45: inside bit 3
        check("mid_txd", txd_o, 1'b0);
        check("mid_status", status_o, 8'h2C);
        rst_i = 1'b0;
        expQ.delete();
        #1;
        check("arst_txd", txd_o, 1'b1);
        check("arst_status", status_o, 8'h02);
        check("arst_ovf", overflow_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        lowCnt = 0;
        for (int i = 0; i < 200; i++) begin
            waitEdges(1);
            if (!txd_o) lowCnt++;
        end
        check("post_rst_low_cycles", lowCnt, 0);
        check("post_rst_status", status_o, 8'h02);

        // 6. Read-only strobes do nothing, then an all-zero byte
        en_i    = 1'b1;
        we_i    = 1'b0;
        wdata_i = 8'h77;
        for (int i = 0; i < 5; i++) begin
            waitEdges(1);
            check("noweStatus", status_o, 8'h02);
            check("noweTxd", txd_o, 1'b1);
        end
        en_i = 1'b0;
        pushByte(8'h00, 1'b1);
        n = 0;
        while (txd_o && n < 20) begin
            waitEdges(1);
            n++;
        end
        lowCnt = 0;
        while (!txd_o && lowCnt < 200) begin
            waitEdges(1);
            lowCnt++;
        end
        check("zero_low_cycles", lowCnt, 90);
        check("zero_stop", txd_o, 1'b1);
        waitEdges(20);
        check("final_drained", expQ.size(), 0);
        check("final_status", status_o, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
